// File: rtl/mux_pkg.sv
// Shared types and defaults for the four-input steering mux.
`timescale 1ns/1ps
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/four_to_one_mux_if.sv
// Data/select bundle for four_to_one_mux; master drives operands and select, slave returns y.
`timescale 1ns/1ps
interface four_to_one_mux_if
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       s;
  logic [WIDTH-1:0] y;

  modport master (
    output a,
    output b,
    output c,
    output d,
    output s,
    input  y
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    input  d,
    input  s,
    output y
  );

endinterface

// File: rtl/mux_out_reg.sv
// Output retiming register with synchronous active-high clear to zero.
`timescale 1ns/1ps
module mux_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d;
    if (rst) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/four_to_one_mux.sv
// Four-way WIDTH-bit mux on a 2-bit select, with an optional 1-cycle output register.
`timescale 1ns/1ps
module four_to_one_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b0
) (
  input logic               clk,
  input logic               rst,
  four_to_one_mux_if.slave  bus
);

  if ((WIDTH < 1) || (WIDTH > 64)) begin : g_width_chk
    $error("four_to_one_mux: WIDTH must be within 1..64");
  end

  logic [WIDTH-1:0] sel_data;

  // Unknown select yields X rather than falling back to any input.
  always_comb begin
    sel_data = 'x;
    unique case (sel_e'(bus.s))
      SEL_A:   sel_data = bus.a;
      SEL_B:   sel_data = bus.b;
      SEL_C:   sel_data = bus.c;
      SEL_D:   sel_data = bus.d;
      default: sel_data = 'x;
    endcase
  end

  if (REG_OUT) begin : g_reg
    mux_out_reg #(
      .WIDTH(WIDTH)
    ) u_out_reg (
      .clk(clk),
      .rst(rst),
      .d  (sel_data),
      .q  (bus.y)
    );
  end else begin : g_comb
    assign bus.y = sel_data;
    // Clock and reset have no role in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};
  end

endmodule

// File: tb/tb_four_to_one_mux.sv
// Self-checking bench: combinational and registered instances driven from shared stimulus.
`timescale 1ns/1ps
module tb_four_to_one_mux;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [1:0] s;
    logic [7:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic [7:0] a, b, c, d;
  logic [1:0] s;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  four_to_one_mux_if #(.WIDTH(8)) if_comb ();
  four_to_one_mux_if #(.WIDTH(8)) if_reg ();

  assign if_comb.a = a;
  assign if_comb.b = b;
  assign if_comb.c = c;
  assign if_comb.d = d;
  assign if_comb.s = s;
  assign if_reg.a  = a;
  assign if_reg.b  = b;
  assign if_reg.c  = c;
  assign if_reg.d  = d;
  assign if_reg.s  = s;

  four_to_one_mux #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
    .clk(clk),
    .rst(rst),
    .bus(if_comb)
  );

  four_to_one_mux #(.WIDTH(8), .REG_OUT(1'b1)) u_reg (
    .clk(clk),
    .rst(rst),
    .bus(if_reg)
  );

  always #5 if (clk_en) clk = ~clk;

  function automatic logic [7:0] golden(input logic [7:0] ia, input logic [7:0] ib,
                                        input logic [7:0] ic, input logic [7:0] id,
                                        input logic [1:0] is);
    logic [7:0] opts [4];
    opts[0] = ia;
    opts[1] = ib;
    opts[2] = ic;
    opts[3] = id;
    return opts[is];
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: y=%h expected=%h", name, got, want);
    end
  endtask

  // Drive values, queue the expected registered result, then compare just after the edge.
  task automatic reg_step(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ic, input logic [7:0] id, input logic [1:0] is,
                          input logic irst);
    logic [7:0] want;
    a = ia; b = ib; c = ic; d = id; s = is; rst = irst;
    exp_q.push_back(irst ? 8'h00 : golden(ia, ib, ic, id, is));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_empty"}, if_reg.y, 8'hxx);
    end else begin
      want = exp_q.pop_front();
      check(name, if_reg.y, want);
    end
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{a: 8'h00, b: 8'h01, c: 8'h02, d: 8'h03, s: 2'b00, y: 8'h00};
    tbl[1] = '{a: 8'h00, b: 8'h01, c: 8'h02, d: 8'h03, s: 2'b01, y: 8'h01};
    tbl[2] = '{a: 8'h00, b: 8'h01, c: 8'h02, d: 8'h03, s: 2'b10, y: 8'h02};
    tbl[3] = '{a: 8'h00, b: 8'h01, c: 8'h02, d: 8'h03, s: 2'b11, y: 8'h03};
    tbl[4] = '{a: 8'hFF, b: 8'h5A, c: 8'hC3, d: 8'h81, s: 2'b00, y: 8'hFF};
    tbl[5] = '{a: 8'h11, b: 8'h22, c: 8'h44, d: 8'h80, s: 2'b11, y: 8'h80};

    // Combinational table, clock idle.
    for (int i = 0; i < 6; i++) begin
      a = tbl[i].a; b = tbl[i].b; c = tbl[i].c; d = tbl[i].d; s = tbl[i].s;
      #10;
      check($sformatf("comb_tbl%0d", i), if_comb.y, tbl[i].y);
    end

    // Data change on the selected input propagates; reset is ignored.
    a = 8'h00; b = 8'h01; c = 8'h02; d = 8'h03; s = 2'b10;
    #1;
    c = 8'hA5;
    #1;
    check("comb_c_change", if_comb.y, 8'hA5);
    rst = 1'b1;
    #1;
    check("comb_rst_ignored", if_comb.y, 8'hA5);
    c = 8'h02;

    clk_en = 1'b1;
    #2;

    // Reset for two edges, then release.
    reg_step("reg_rst0", 8'h00, 8'h01, 8'h02, 8'h03, 2'b11, 1'b1);
    reg_step("reg_rst1", 8'h00, 8'h01, 8'h02, 8'h03, 2'b11, 1'b1);
    reg_step("reg_release", 8'h00, 8'h01, 8'h02, 8'h03, 2'b11, 1'b0);

    // Select change between edges takes effect only at the next edge.
    reg_step("reg_s00", 8'h00, 8'h01, 8'h02, 8'h03, 2'b00, 1'b0);
    s = 2'b01;
    #3;
    check("reg_hold", if_reg.y, 8'h00);
    reg_step("reg_s01", 8'h00, 8'h01, 8'h02, 8'h03, 2'b01, 1'b0);

    // Stream with reset landing on the third edge.
    reg_step("reg_stream01", 8'h00, 8'h01, 8'h02, 8'h03, 2'b01, 1'b0);
    reg_step("reg_stream10", 8'h00, 8'h01, 8'h02, 8'h03, 2'b10, 1'b0);
    reg_step("reg_stream_rst", 8'h00, 8'h01, 8'h02, 8'h03, 2'b11, 1'b1);

    // Registered table through the same stepping path.
    for (int i = 0; i < 6; i++) begin
      reg_step($sformatf("reg_tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d,
               tbl[i].s, 1'b0);
    end

    // Random vectors on both builds.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb, rc, rd, want;
      logic [1:0] rs;
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      a = ra; b = rb; c = rc; d = rd; s = rs; rst = 1'b0;
      #1;
      check("comb_rand", if_comb.y, golden(ra, rb, rc, rd, rs));
      exp_q.push_back(golden(ra, rb, rc, rd, rs));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("reg_rand_empty", if_reg.y, 8'hxx);
      end else begin
        want = exp_q.pop_front();
        check("reg_rand", if_reg.y, want);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
